// File: rtl/bomb_field_pkg.sv
// Shared types, screen limits and the gravity-threshold helper for the bomb field.
package bomb_field_pkg;

   typedef enum logic [1:0] {IDLE, FALLING, EXPLODE} slot_state_t;

   localparam logic [9:0] X_MAX = 10'd639;
   localparam logic [9:0] Y_MAX = 10'd479;

   // Frames per +1 velocity step: base - 2*level at 6 bits signed, floored at 1.
   function automatic logic [4:0] grav_thr(input logic [4:0] base, input logic [3:0] level);
      logic signed [5:0] t;
      t = $signed({1'b0, base}) - $signed({1'b0, level, 1'b0});
      if (t < 6'sd1) return 5'd1;
      return t[4:0];
   endfunction

endpackage

// File: rtl/bomb_field_if.sv
// Game-state / sprite-mapper side bus of the bomb field.
interface bomb_field_if #(parameter int N_BOMBS = 4);
   logic                   enable;
   logic [3:0]             level;
   logic [9:0]             playerX;
   logic [9:0]             playerY;
   logic [10*N_BOMBS-1:0]  bombX;
   logic [10*N_BOMBS-1:0]  bombY;
   logic [N_BOMBS-1:0]     active;
   logic [N_BOMBS-1:0]     exploding;
   logic                   landed_pulse;
   logic                   caught_pulse;

   modport master (output enable, level, playerX, playerY,
                   input  bombX, bombY, active, exploding, landed_pulse, caught_pulse);
   modport slave  (input  enable, level, playerX, playerY,
                   output bombX, bombY, active, exploding, landed_pulse, caught_pulse);
endinterface

// File: rtl/bomb_field_slot.sv
// One bomb slot: IDLE -> FALLING -> (caught: IDLE | landed: EXPLODE -> IDLE).
module bomb_field_slot import bomb_field_pkg::*; #(
   parameter logic [9:0] SPAWN_Y        = 10'd16,
   parameter logic [9:0] FLOOR_Y        = 10'd479,
   parameter logic [9:0] VMAX           = 10'd12,
   parameter logic [4:0] EXPLODE_FRAMES = 5'd16,
   parameter logic [9:0] CATCH_HALF     = 10'd12
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        enable_i,
   input  logic        spawn_i,
   input  logic [9:0]  spawn_x_i,
   input  logic [4:0]  thr_i,
   input  logic [9:0]  player_x_i,
   input  logic [9:0]  player_y_i,
   output logic [9:0]  x_o,
   output logic [9:0]  y_o,
   output slot_state_t state_o,
   output logic        land_o,
   output logic        catch_o
);
   slot_state_t state_q, state_d;
   logic [9:0]  x_q, x_d, y_q, y_d, vel_q, vel_d;
   logic [4:0]  ctr_q, ctr_d;
   logic [9:0]  dx, dy;
   logic [10:0] y_probe;
   logic        in_box, hit_floor, exp_done;

   // Catch box uses the registered position; the floor probe is 11 bits so it never wraps.
   assign dx        = (x_q >= player_x_i) ? x_q - player_x_i : player_x_i - x_q;
   assign dy        = (y_q >= player_y_i) ? y_q - player_y_i : player_y_i - y_q;
   assign in_box    = (dx <= CATCH_HALF) && (dy <= CATCH_HALF);
   assign y_probe   = {1'b0, y_q} + {1'b0, vel_q} + 11'd1;
   assign hit_floor = y_probe >= {1'b0, FLOOR_Y};
   assign exp_done  = ctr_q == EXPLODE_FRAMES - 5'd1;

   // State register.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state; catch takes priority over landing.
   always_comb begin
      state_d = state_q;
      if (enable_i) begin
         case (state_q)
            IDLE:    if (spawn_i) state_d = FALLING;
            FALLING: if (in_box) state_d = IDLE;
                     else if (hit_floor) state_d = EXPLODE;
            EXPLODE: if (exp_done) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath next values and the land/catch strobes for this frame.
   always_comb begin
      x_d = x_q; y_d = y_q; vel_d = vel_q; ctr_d = ctr_q;
      land_o = 1'b0; catch_o = 1'b0;
      if (enable_i) begin
         case (state_q)
            IDLE: if (spawn_i) begin
               x_d = spawn_x_i; y_d = SPAWN_Y; vel_d = '0; ctr_d = '0;
            end
            FALLING: if (in_box) begin
               y_d = SPAWN_Y; vel_d = '0; ctr_d = '0; catch_o = 1'b1;
            end else if (hit_floor) begin
               y_d = FLOOR_Y; vel_d = '0; ctr_d = '0; land_o = 1'b1;
            end else begin
               y_d = y_q + vel_q;
               if (ctr_q == thr_i - 5'd1) begin
                  vel_d = (vel_q >= VMAX) ? VMAX : vel_q + 10'd1;
                  ctr_d = '0;
               end else begin
                  ctr_d = ctr_q + 5'd1;
               end
            end
            EXPLODE: if (exp_done) begin
               ctr_d = '0; y_d = SPAWN_Y;
            end else begin
               ctr_d = ctr_q + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // Position, velocity and frame counter registers.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         x_q <= '0; y_q <= SPAWN_Y; vel_q <= '0; ctr_q <= '0;
      end else begin
         x_q <= x_d; y_q <= y_d; vel_q <= vel_d; ctr_q <= ctr_d;
      end
   end

   assign x_o     = x_q;
   assign y_o     = y_q;
   assign state_o = state_q;
endmodule

// File: rtl/bomb_field.sv
// Multi-bomb manager: spawn LFSR, spawn timer, lowest-idle allocation and event pulses.
module bomb_field import bomb_field_pkg::*; #(
   parameter int         N_BOMBS        = 4,
   parameter logic [9:0] SPAWN_Y        = 10'd16,
   parameter logic [9:0] FLOOR_Y        = Y_MAX,
   parameter logic [9:0] SPAWN_X_MIN    = 10'd64,
   parameter logic [7:0] SPAWN_PERIOD   = 8'd60,
   parameter logic [4:0] GRAV_BASE      = 5'd20,
   parameter logic [9:0] VMAX           = 10'd12,
   parameter logic [4:0] EXPLODE_FRAMES = 5'd16,
   parameter logic [9:0] CATCH_HALF     = 10'd12
) (
   input logic        frame_clk,
   input logic        Reset,
   bomb_field_if.slave bus
);
   logic [9:0]               lfsr_q, lfsr_d;
   logic [7:0]               spawn_ctr_q, spawn_ctr_d;
   logic                     land_pulse_q, catch_pulse_q;
   logic [N_BOMBS-1:0]       idle, idle_lo, spawn_sel, land_s, catch_s, act_s, exp_s;
   logic [N_BOMBS-1:0][9:0]  x_s, y_s;
   slot_state_t              st_s [N_BOMBS];
   logic [4:0]               thr;
   logic [10:0]              spawn_sum;
   logic [9:0]               spawn_x;
   logic                     spawn_req, spawn_go;

   assign thr       = grav_thr(GRAV_BASE, bus.level);
   assign spawn_sum = {1'b0, SPAWN_X_MIN} + {2'b00, lfsr_q[8:0]};
   assign spawn_x   = (spawn_sum > {1'b0, X_MAX}) ? X_MAX : spawn_sum[9:0];
   assign spawn_req = spawn_ctr_q == SPAWN_PERIOD - 8'd1;
   assign spawn_go  = bus.enable && spawn_req && (|idle);
   // Isolate the lowest set bit: only that IDLE slot takes the spawn.
   assign idle_lo   = idle & (~idle + N_BOMBS'(1));
   assign spawn_sel = idle_lo & {N_BOMBS{spawn_go}};

   // Spawn timer saturates at the request value until some slot is free.
   always_comb begin
      spawn_ctr_d = spawn_ctr_q;
      lfsr_d      = lfsr_q;
      if (bus.enable) begin
         lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
         if (!spawn_req)  spawn_ctr_d = spawn_ctr_q + 8'd1;
         else if (|idle)  spawn_ctr_d = '0;
      end
   end

   // Global registers; pulses are cleared whenever the field is frozen.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         lfsr_q <= 10'h001; spawn_ctr_q <= '0;
         land_pulse_q <= 1'b0; catch_pulse_q <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d; spawn_ctr_q <= spawn_ctr_d;
         land_pulse_q  <= bus.enable && (|land_s);
         catch_pulse_q <= bus.enable && (|catch_s);
      end
   end

   for (genvar g = 0; g < N_BOMBS; g++) begin : g_slot
      bomb_field_slot #(
         .SPAWN_Y(SPAWN_Y), .FLOOR_Y(FLOOR_Y), .VMAX(VMAX),
         .EXPLODE_FRAMES(EXPLODE_FRAMES), .CATCH_HALF(CATCH_HALF)
      ) u_slot (
         .frame_clk (frame_clk),
         .Reset     (Reset),
         .enable_i  (bus.enable),
         .spawn_i   (spawn_sel[g]),
         .spawn_x_i (spawn_x),
         .thr_i     (thr),
         .player_x_i(bus.playerX),
         .player_y_i(bus.playerY),
         .x_o       (x_s[g]),
         .y_o       (y_s[g]),
         .state_o   (st_s[g]),
         .land_o    (land_s[g]),
         .catch_o   (catch_s[g])
      );
      assign idle[g]  = st_s[g] == IDLE;
      assign act_s[g] = st_s[g] == FALLING;
      assign exp_s[g] = st_s[g] == EXPLODE;
   end

   assign bus.bombX        = x_s;
   assign bus.bombY        = y_s;
   assign bus.active       = act_s;
   assign bus.exploding    = exp_s;
   assign bus.landed_pulse = land_pulse_q;
   assign bus.caught_pulse = catch_pulse_q;
endmodule
